fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipeline. It owns the architectural PC register and drives a single-outstanding request/response port to instruction memory. It delivers fetched instructions through the IF/ID output register and one skid entry under ID backpressure. It consumes the EX-stage next-PC result as a redirect and flushes wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  one-cycle pulse from EX: taken branch/jump resolved, fetch path is wrong.
- redirect_pc  in  32  redirect target (EX next-PC value); bits [1:0] ignored, forced to 0.
- stall  in  1  ID cannot accept; IF/ID contents must hold.
- imem_req  out  1  fetch request; held high until imem_rvalid.
- imem_addr  out  32  word address of outstanding request; stable while imem_req high.
- imem_rvalid  in  1  response for current request; legal only while imem_req high, including its first cycle.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- if_valid  out  1  IF/ID holds a live instruction.
- if_pc  out  32  PC of if_inst.
- if_inst  out  32  instruction word.
- if_pc4  out  32  if_pc + 4, combinational, mod 2^32.

## Operation
- Registers: pc, req_addr, state, skid_valid, skid_pc, skid_inst, and IF/ID (if_valid, if_pc, if_inst).
- Reset values: pc = RESET_PC, state = FETCH, if_valid = 0, if_pc = 0, if_inst = 0, skid_valid = 0.
- imem_req is 0 while rst is high. if_pc4 reads 0x4 during reset.
- slot_free = !if_valid || !stall.
- FETCH: imem_req = 1, imem_addr = pc.
  - rvalid && slot_free: IF/ID <= {1, pc, rdata}; pc <= pc + 4; stay in FETCH.
  - rvalid && !slot_free: skid <= {pc, rdata}; pc <= pc + 4; go to HOLD.
  - no rvalid && if_valid && !stall: if_valid <= 0.
- HOLD: imem_req = 0.
  - While stall is high, IF/ID and skid hold.
  - When stall is low: IF/ID <= skid; skid_valid <= 0; go to FETCH.
- DROP: imem_req = 1, imem_addr = req_addr (the stale address).
  - On rvalid: data discarded; go to FETCH (new request from pc begins the next cycle).
- Redirect: top priority over stall and rvalid in every state.
  - Effects: pc <= {redirect_pc[31:2], 2'b00}; if_valid <= 0; skid_valid <= 0.
  - FETCH, no rvalid same cycle: req_addr <= pc (the old one); go to DROP.
  - FETCH with rvalid same cycle: response discarded; stay in FETCH.
  - HOLD: go to FETCH.
  - DROP, no rvalid: stay in DROP; pc takes the newest target.
  - DROP with rvalid: go to FETCH.
- PC arithmetic is 32-bit unsigned and wraps: 0xFFFF_FFFC + 4 = 0x0000_0000.
- At most one request is outstanding. No response is ever delivered to IF/ID for an address issued before the latest redirect.

## Timing
- Zero-wait memory (rvalid in the first cycle of req): one instruction per cycle. IF/ID updates on the edge ending the rvalid cycle.
- N-cycle memory: if_valid rises on the edge after the rvalid cycle; throughput is one instruction per (N+1) cycles.
- Redirect in cycle k: if_valid = 0 in cycle k+1. The first fetch of the target is:
  - cycle k+1 when the state was FETCH-with-rvalid or HOLD;
  - one cycle after the stale rvalid when the state was DROP.
- imem_addr changes only on the edge after rvalid, or on the edge after DROP exits.
- Stall releases in HOLD in cycle k: skid instruction appears in IF/ID in cycle k+1; imem_req reasserts in cycle k+1.
- Reset asserted in any state, including DROP: all registers reset on the next edge. The memory side shares rst, so no stale response is honoured.

## Test plan
- Reset, zero-wait memory returning addr^0xA5A5_0000: fetches at 0x0, 0x4, 0x8, one per cycle. if_pc/if_inst match; if_pc4 = 0x4, 0x8, 0xC.
- Stall held 3 cycles while rvalid arrives for 0x8: state HOLD, imem_req = 0, IF/ID keeps 0x4. On release, 0x8 appears the next cycle, then 0xC; no loss, no duplicates.
- 3-cycle memory, redirect to 0x100 one cycle after request 0x10 is issued: imem_addr stays 0x10 until rvalid, data discarded, if_valid stays 0, next imem_addr = 0x100.
- Redirect to 0x203 in the same cycle as rvalid for 0x20: response dropped, next imem_addr = 0x200, if_valid = 0 for one cycle.
- Redirect during HOLD with stall high: skid and IF/ID cleared the next cycle, FETCH from the target. A second redirect while in DROP: only the latest target is fetched.
- RESET_PC = 0xFFFF_FFFC: second fetch address is 0x0000_0000. rst pulsed while in DROP: imem_req = 0 during reset, then a fetch from 0xFFFF_FFFC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem port,
// and feeds ID through the IF/ID register plus one skid entry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_reqAddr;
  logic        r_skidValid;
  logic [31:0] r_skidPc;
  logic [31:0] r_skidInst;
  logic        r_ifValid;
  logic [31:0] r_ifPc;
  logic [31:0] r_ifInst;

  logic        w_slotFree;
  logic        w_rsp;
  logic [31:0] w_target;
  logic [31:0] w_pcNext;

  assign imem_req   = !rst && (r_state != HOLD);
  assign imem_addr  = (r_state == DROP) ? r_reqAddr : r_pc;
  assign w_rsp      = imem_rvalid && imem_req;
  assign w_slotFree = !r_ifValid || !stall;
  assign w_target   = redirect_pc & 32'hFFFF_FFFC;
  assign w_pcNext   = r_pc + 32'd4;

  assign if_valid = r_ifValid;
  assign if_pc    = r_ifPc;
  assign if_inst  = r_ifInst;
  assign if_pc4   = rst ? 32'd4 : (r_ifPc + 32'd4);

  // Redirect outranks everything; a response in flight for a pre-redirect
  // address is either dropped on arrival or drained through DROP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_reqAddr   <= 32'd0;
      r_skidValid <= 1'b0;
      r_skidPc    <= 32'd0;
      r_skidInst  <= 32'd0;
      r_ifValid   <= 1'b0;
      r_ifPc      <= 32'd0;
      r_ifInst    <= 32'd0;
    end else if (redirect) begin
      r_pc        <= w_target;
      r_ifValid   <= 1'b0;
      r_skidValid <= 1'b0;
      case (r_state)
        FETCH: begin
          if (!w_rsp) begin
            r_reqAddr <= r_pc;
            r_state   <= DROP;
          end
        end
        HOLD:    r_state <= FETCH;
        DROP:    if (w_rsp) r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (w_rsp) begin
            r_pc <= w_pcNext;
            if (w_slotFree) begin
              r_ifValid <= 1'b1;
              r_ifPc    <= r_pc;
              r_ifInst  <= imem_rdata;
            end else begin
              r_skidValid <= 1'b1;
              r_skidPc    <= r_pc;
              r_skidInst  <= imem_rdata;
              r_state     <= HOLD;
            end
          end else if (r_ifValid && !stall) begin
            r_ifValid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            r_ifValid   <= r_skidValid;
            r_ifPc      <= r_skidPc;
            r_ifInst    <= r_skidInst;
            r_skidValid <= 1'b0;
            r_state     <= FETCH;
          end
        end
        DROP: begin
          if (w_rsp) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/stall/redirect sequences
// against a small latency-programmable instruction memory model.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        stall;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        ifValid;
  logic [31:0] ifPc;
  logic [31:0] ifInst;
  logic [31:0] ifPc4;
  int          memLat;
  int          memCnt;

  logic        rst2;
  logic        redirect2;
  logic [31:0] redirectPc2;
  logic        stall2;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic        imemRvalid2;
  logic [31:0] imemRdata2;
  logic        ifValid2;
  logic [31:0] ifPc2;
  logic [31:0] ifInst2;
  logic [31:0] ifPc42;
  int          memLat2;
  int          memCnt2;

  int   totalChecks = 0;
  int   badChecks = 0;
  exp_t expQ[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirectPc),
    .stall(stall), .imem_req(imemReq), .imem_addr(imemAddr),
    .imem_rvalid(imemRvalid), .imem_rdata(imemRdata), .if_valid(ifValid),
    .if_pc(ifPc), .if_inst(ifInst), .if_pc4(ifPc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .redirect(redirect2), .redirect_pc(redirectPc2),
    .stall(stall2), .imem_req(imemReq2), .imem_addr(imemAddr2),
    .imem_rvalid(imemRvalid2), .imem_rdata(imemRdata2), .if_valid(ifValid2),
    .if_pc(ifPc2), .if_inst(ifInst2), .if_pc4(ifPc42)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers memLat cycles after a request first appears.
  assign imemRvalid  = imemReq && (memCnt >= memLat);
  assign imemRdata   = imemAddr ^ 32'hA5A5_0000;
  assign imemRvalid2 = imemReq2 && (memCnt2 >= memLat2);
  assign imemRdata2  = imemAddr2 ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (rst || !imemReq || imemRvalid) memCnt <= 0;
    else memCnt <= memCnt + 1;
    if (rst2 || !imemReq2 || imemRvalid2) memCnt2 <= 0;
    else memCnt2 <= memCnt2 + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] rdPc, input logic st);
    redirect   = rd;
    redirectPc = rdPc;
    stall      = st;
    #1;
  endtask

  task automatic pushExp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = pc ^ 32'hA5A5_0000;
    expQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // An instruction is consumed by ID whenever IF/ID is live and not stalled.
  always @(negedge clk) begin
    if (ifValid === 1'b1 && stall === 1'b0) begin
      if (expQ.size() == 0) begin
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL extra_delivery: got pc=%h required=nothing", ifPc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("deliver_pc", ifPc, e.pc);
        checkOutput("deliver_inst", ifInst, e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    memLat = 0; memLat2 = 0;
    redirect2 = 1'b0; redirectPc2 = 32'd0; stall2 = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("rst_req", {31'd0, imemReq}, 32'd0);
    checkOutput("rst_pc4", ifPc4, 32'h4);
    nextCycle();
    nextCycle();
    checkOutput("rst_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("rst_ifpc", ifPc, 32'd0);
    checkOutput("rst_inst", ifInst, 32'd0);

    // Zero-wait streaming from 0x0
    rst = 1'b0; pushExp(32'h0); #1;
    checkOutput("c0_req", {31'd0, imemReq}, 32'd1);
    checkOutput("c0_addr", imemAddr, 32'h0);
    nextCycle(); pushExp(32'h4);
    checkOutput("c1_addr", imemAddr, 32'h4);
    checkOutput("c1_valid", {31'd0, ifValid}, 32'd1);
    checkOutput("c1_pc4", ifPc4, 32'h4);

    // Stall for three cycles while 0x8 returns
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b1); pushExp(32'h8);
    checkOutput("c2_addr", imemAddr, 32'h8);
    checkOutput("c2_pc4", ifPc4, 32'h8);
    nextCycle();
    checkOutput("c3_hold_req", {31'd0, imemReq}, 32'd0);
    checkOutput("c3_ifpc", ifPc, 32'h4);
    nextCycle();
    checkOutput("c4_ifpc", ifPc, 32'h4);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("c5_ifpc", ifPc, 32'h4);
    checkOutput("c5_req", {31'd0, imemReq}, 32'd0);
    nextCycle(); pushExp(32'hC);
    checkOutput("c6_ifpc", ifPc, 32'h8);
    checkOutput("c6_req", {31'd0, imemReq}, 32'd1);
    checkOutput("c6_addr", imemAddr, 32'hC);
    checkOutput("c6_pc4", ifPc4, 32'hC);

    // Slow memory, redirect while 0x10 is outstanding
    nextCycle(); memLat = 3; #1;
    checkOutput("c7_addr", imemAddr, 32'h10);
    checkOutput("c7_ifpc", ifPc, 32'hC);
    nextCycle(); applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("c8_addr", imemAddr, 32'h10);
    checkOutput("c8_valid", {31'd0, ifValid}, 32'd0);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("c9_drop_addr", imemAddr, 32'h10);
    nextCycle();
    checkOutput("c10_drop_addr", imemAddr, 32'h10);
    checkOutput("c10_valid", {31'd0, ifValid}, 32'd0);
    nextCycle(); memLat = 0; pushExp(32'h100); #1;
    checkOutput("c11_addr", imemAddr, 32'h100);
    checkOutput("c11_valid", {31'd0, ifValid}, 32'd0);

    // Redirects coinciding with responses
    nextCycle(); applyStimulus(1'b1, 32'h1C, 1'b0);
    checkOutput("c12_addr", imemAddr, 32'h104);
    checkOutput("c12_ifpc", ifPc, 32'h100);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0); pushExp(32'h1C);
    checkOutput("c13_addr", imemAddr, 32'h1C);
    checkOutput("c13_valid", {31'd0, ifValid}, 32'd0);
    nextCycle(); applyStimulus(1'b1, 32'h203, 1'b0);
    checkOutput("c14_addr", imemAddr, 32'h20);
    checkOutput("c14_ifpc", ifPc, 32'h1C);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("c15_addr", imemAddr, 32'h200);
    checkOutput("c15_valid", {31'd0, ifValid}, 32'd0);

    // Redirect while in HOLD; 0x200 is flushed without being consumed
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("c16_ifpc", ifPc, 32'h200);
    checkOutput("c16_addr", imemAddr, 32'h204);
    nextCycle(); applyStimulus(1'b1, 32'h300, 1'b1);
    checkOutput("c17_req", {31'd0, imemReq}, 32'd0);
    checkOutput("c17_valid", {31'd0, ifValid}, 32'd1);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0); memLat = 3;
    checkOutput("c18_valid", {31'd0, ifValid}, 32'd0);
    checkOutput("c18_req", {31'd0, imemReq}, 32'd1);
    checkOutput("c18_addr", imemAddr, 32'h300);

    // Two redirects while draining a stale request
    nextCycle(); applyStimulus(1'b1, 32'h400, 1'b0);
    checkOutput("c19_addr", imemAddr, 32'h300);
    nextCycle(); applyStimulus(1'b1, 32'h500, 1'b0);
    checkOutput("c20_addr", imemAddr, 32'h300);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("c21_addr", imemAddr, 32'h300);
    nextCycle(); memLat = 0; pushExp(32'h500); #1;
    checkOutput("c22_addr", imemAddr, 32'h500);
    checkOutput("c22_valid", {31'd0, ifValid}, 32'd0);
    nextCycle();
    checkOutput("c23_ifpc", ifPc, 32'h500);
    checkOutput("c23_addr", imemAddr, 32'h504);
    nextCycle(); applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("c24_ifpc", ifPc, 32'h504);
    nextCycle();
    checkOutput("c25_hold_req", {31'd0, imemReq}, 32'd0);
    nextCycle();
    checkOutput("queue_drained", expQ.size(), 32'd0);

    // Wrap-around reset PC and reset taken while in DROP
    rst2 = 1'b0; #1;
    checkOutput("d0_req", {31'd0, imemReq2}, 32'd1);
    checkOutput("d0_addr", imemAddr2, 32'hFFFF_FFFC);
    nextCycle();
    checkOutput("d1_addr_wrap", imemAddr2, 32'h0);
    checkOutput("d1_ifpc", ifPc2, 32'hFFFF_FFFC);
    checkOutput("d1_pc4_wrap", ifPc42, 32'h0);
    checkOutput("d1_inst", ifInst2, 32'h5A5A_FFFC);
    nextCycle(); memLat2 = 3; #1;
    checkOutput("d2_addr", imemAddr2, 32'h4);
    nextCycle(); redirect2 = 1'b1; redirectPc2 = 32'h40; #1;
    checkOutput("d3_addr", imemAddr2, 32'h4);
    nextCycle(); redirect2 = 1'b0; rst2 = 1'b1; #1;
    checkOutput("d4_rst_req", {31'd0, imemReq2}, 32'd0);
    checkOutput("d4_rst_pc4", ifPc42, 32'h4);
    nextCycle(); rst2 = 1'b0; #1;
    checkOutput("d5_req", {31'd0, imemReq2}, 32'd1);
    checkOutput("d5_addr", imemAddr2, 32'hFFFF_FFFC);
    checkOutput("d5_valid", {31'd0, ifValid2}, 32'd0);

    nextCycle();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
